// File: rtl/sweep_scheduler_if.sv
// Grid-load stream and result handshake between the loader/sink side and sweep_scheduler.
// The scheduler is the slave; whoever feeds rows and consumes results is the master.
interface sweep_scheduler_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(WIDTH*DEPTH+1);

  logic             start;
  logic             row_valid;
  logic             row_ready;
  logic [WIDTH-1:0] row_data;
  logic             busy;
  logic             done;
  logic             res_ready;
  logic [CW-1:0]    count;
  logic [CW-1:0]    sweeps;
  logic             truncated;

  modport master (
    output start, row_valid, row_data, res_ready,
    input  row_ready, busy, done, count, sweeps, truncated
  );

  modport slave (
    input  start, row_valid, row_data, res_ready,
    output row_ready, busy, done, count, sweeps, truncated
  );
endinterface

// File: rtl/sweep_scheduler.sv
// Loads an occupancy grid row by row, then applies one datapath sweep per clock until nothing is
// removed, and holds the totals on a result handshake. Optional sweep cap: define SWEEP_LIMIT_EN.
module sweep_scheduler #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 16,
  parameter int MAX_SWEEPS = 255,
  localparam int CW        = $clog2(WIDTH*DEPTH+1)
) (
  input  logic                        clk,
  input  logic                        reset,
  sweep_scheduler_if.slave            bus,
  output logic [DEPTH-1:0][WIDTH-1:0] dp_mat_in,
  input  logic [DEPTH-1:0][WIDTH-1:0] dp_mat_out,
  input  logic [CW-1:0]               dp_removed,
  output logic [1:0]                  dbg_state
);
  localparam int RW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SWEEP, DONE} state_t;

  state_t                      state_q, state_d;
  logic [RW-1:0]               row_idx_q;
  logic [DEPTH-1:0][WIDTH-1:0] grid_q;
  logic [CW-1:0]               count_q;
  logic [CW-1:0]               sweeps_q;
  logic                        trunc_q;
  logic                        cap_hit;
  logic                        row_fire;
  logic                        last_row;
  logic                        sweep_upd;

`ifdef SWEEP_LIMIT_EN
  assign cap_hit = (state_q == SWEEP) && (sweeps_q == CW'(MAX_SWEEPS)) && (dp_removed != '0);
`else
  localparam int unused_max_sweeps = MAX_SWEEPS;
  assign cap_hit = 1'b0;
`endif

  // Handshakes: a row transfers on any rising edge where row_valid && row_ready; the result
  // transfers on any rising edge where done && res_ready. Neither side may retract early.
  assign row_fire  = (state_q == LOAD) && bus.row_valid;
  assign last_row  = (row_idx_q == RW'(DEPTH-1));
  assign sweep_upd = (state_q == SWEEP) && (dp_removed != '0) && !cap_hit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = LOAD;
      LOAD:    if (row_fire && last_row) state_d = SWEEP;
      SWEEP:   if ((dp_removed == '0) || cap_hit) state_d = DONE;
      DONE:    if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      row_idx_q <= '0;
      grid_q    <= '0;
      count_q   <= '0;
      sweeps_q  <= '0;
      trunc_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            row_idx_q <= '0;
            count_q   <= '0;
            sweeps_q  <= '0;
            trunc_q   <= 1'b0;
          end
        end
        LOAD: begin
          if (row_fire) begin
            grid_q[row_idx_q] <= bus.row_data;
            row_idx_q         <= row_idx_q + 1'b1;
          end
        end
        SWEEP: begin
          if (sweep_upd) begin
            grid_q   <= dp_mat_out;
            count_q  <= count_q + dp_removed;
            sweeps_q <= sweeps_q + 1'b1;
          end
          if (cap_hit) trunc_q <= 1'b1;
        end
        DONE: begin
          // Leaving DONE returns every output, including the grid, to zero for IDLE.
          if (bus.res_ready) begin
            grid_q   <= '0;
            count_q  <= '0;
            sweeps_q <= '0;
            trunc_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.row_ready = (state_q == LOAD);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.count     = count_q;
  assign bus.sweeps    = sweeps_q;
  assign bus.truncated = trunc_q;
  assign dp_mat_in     = grid_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_sweep_scheduler.sv
// Directed bench for sweep_scheduler with a behavioural one-sweep removal datapath
// (a cell with fewer than 4 occupied 8-neighbours is removed) and a scoreboard on the result handshake.
module tb_sweep_scheduler;
  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(WIDTH*DEPTH+1);
  localparam int W     = 8 + 1 + 2*CW;
`ifdef SWEEP_LIMIT_EN
  localparam int MAXS  = 2;
`else
  localparam int MAXS  = 255;
`endif

  logic                        clk;
  logic                        reset;
  logic [DEPTH-1:0][WIDTH-1:0] dp_mat_in;
  logic [DEPTH-1:0][WIDTH-1:0] dp_mat_out;
  logic [CW-1:0]               dp_removed;
  logic [1:0]                  dbg_state;

  sweep_scheduler_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  sweep_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_SWEEPS(MAXS)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .dp_mat_in  (dp_mat_in),
    .dp_mat_out (dp_mat_out),
    .dp_removed (dp_removed),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- datapath model ----------------
  always_comb begin
    int n, rr, cc;
    dp_mat_out = dp_mat_in;
    dp_removed = '0;
    for (int r = 0; r < DEPTH; r++) begin
      for (int c = 0; c < WIDTH; c++) begin
        if (dp_mat_in[r][c]) begin
          n = 0;
          for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
              rr = r + dr;
              cc = c + dc;
              if (!(dr == 0 && dc == 0) && rr >= 0 && rr < DEPTH && cc >= 0 && cc < WIDTH)
                if (dp_mat_in[rr][cc]) n++;
            end
          end
          if (n < 4) begin
            dp_mat_out[r][c] = 1'b0;
            dp_removed = dp_removed + 1'b1;
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  int   last_acc = 0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (reset && bus.row_valid && bus.row_ready) last_acc = cyc + 1;
    if (bus.done && !prev_done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("res_count",     bus.count,            e[CW-1:0]);
        chk("res_sweeps",    bus.sweeps,           e[2*CW-1:CW]);
        chk("res_truncated", bus.truncated,        e[2*CW]);
        chk("res_latency",   cyc - last_acc + 1,   e[2*CW+8:2*CW+1]);
      end
    end
    prev_done = bus.done;
  end

  // ---------------- driver tasks ----------------
  task automatic load_grid(input logic [DEPTH-1:0][WIDTH-1:0] g, input bit gaps, input bit poke);
    bit ok;
    for (int r = 0; r < DEPTH; r++) begin
      bus.row_valid = 1'b1;
      bus.row_data  = g[r];
      bus.start     = poke && (r == 8);
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (bus.row_ready) begin
          ok = 1'b1;
          @(posedge clk); #1;
          break;
        end
      end
      if (!ok) chk("row_accept_timeout", 0, 1);
      bus.row_valid = 1'b0;
      bus.start     = 1'b0;
      if (gaps && r != DEPTH-1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("row_ready_after_start", bus.row_ready, 1);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", seen, 1);
  endtask

  task automatic run_job(input logic [DEPTH-1:0][WIDTH-1:0] g, input bit gaps, input bit poke_load,
                         input bit poke_sweep, input int hold, input bit start_with_res,
                         input logic [CW-1:0] e_count, input logic [CW-1:0] e_sweeps,
                         input logic e_trunc, input logic [7:0] e_lat);
    exp_q.push_back({e_lat, e_trunc, e_sweeps, e_count});
    pulse_start();
    load_grid(g, gaps, poke_load);
    if (poke_sweep) begin
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    wait_done();
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_done",  bus.done,   1);
      chk("hold_count", bus.count,  e_count);
    end
    bus.res_ready = 1'b1;
    bus.start     = start_with_res;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    bus.start     = 1'b0;
    chk("done_cleared",  bus.done,  0);
    chk("busy_cleared",  bus.busy,  0);
    chk("count_cleared", bus.count, 0);
    if (start_with_res) begin
      repeat (3) begin @(posedge clk); #1; end
      chk("no_new_job_busy",  bus.busy,      0);
      chk("no_new_job_ready", bus.row_ready, 0);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [DEPTH-1:0][WIDTH-1:0] g_zero, g_ones, g_blk, g_one;

  initial begin
    g_zero = '0;
    g_ones = '1;
    g_blk  = '0;
    for (int r = 4; r <= 6; r++)
      for (int c = 4; c <= 6; c++) g_blk[r][c] = 1'b1;
    g_one = '0;
    g_one[5][5] = 1'b1;

    bus.start = 1'b0; bus.row_valid = 1'b0; bus.row_data = '0; bus.res_ready = 1'b0;
    reset = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_busy",      bus.busy,      0);
    chk("rst_done",      bus.done,      0);
    chk("rst_row_ready", bus.row_ready, 0);
    chk("rst_count",     bus.count,     0);
    chk("rst_sweeps",    bus.sweeps,    0);
    chk("rst_truncated", bus.truncated, 0);
    chk("rst_grid",      |dp_mat_in,    0);
    chk("rst_state",     dbg_state,     0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_job(g_zero, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    run_job(g_ones, 0, 1, 0, 0, 0, 4, 1, 0, 3);
`ifdef SWEEP_LIMIT_EN
    run_job(g_blk,  0, 0, 1, 0, 0, 8, 2, 1, 4);
`else
    run_job(g_blk,  0, 0, 1, 0, 0, 9, 3, 0, 5);
`endif
    run_job(g_one,  1, 0, 0, 10, 0, 1, 1, 0, 3);
    run_job(g_ones, 0, 0, 0, 0, 1, 4, 1, 0, 3);

    // Abort the block job one cycle into SWEEP.
    pulse_start();
    load_grid(g_blk, 0, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy",      bus.busy,      0);
    chk("abort_done",      bus.done,      0);
    chk("abort_count",     bus.count,     0);
    chk("abort_sweeps",    bus.sweeps,    0);
    chk("abort_row_ready", bus.row_ready, 0);
    chk("abort_grid",      |dp_mat_in,    0);
    reset = 1'b1;
    @(posedge clk); #1;

`ifdef SWEEP_LIMIT_EN
    run_job(g_blk, 0, 0, 0, 0, 0, 8, 2, 1, 4);
`else
    run_job(g_blk, 0, 0, 0, 0, 0, 9, 3, 0, 5);
`endif

    repeat (3) begin @(posedge clk); #1; end
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t expected=finish", $time);
    $fatal(1, "timeout");
  end
endmodule
